// File: rtl/mips_multicycle_sim.sv
// Multi-cycle MIPS subset simulator. A FETCH/DECODE/EXEC/MEM/WB state machine executes
// from an internal instruction memory, with a run gate, sticky error halt and saturating counters.
module mips_multicycle_sim #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    output logic             halted_o,
    output logic             err_o,
    output logic [31:0]      pc_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o
);
    localparam int          IAW        = $clog2(IMEM_DEPTH);
    localparam int          DAW        = $clog2(DMEM_DEPTH);
    localparam logic [29:0] IMEM_WORDS = 30'(IMEM_DEPTH);
    localparam logic [29:0] DMEM_WORDS = 30'(DMEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    logic        [31:0] Instr_Mem [IMEM_DEPTH];
    logic        [31:0] Data_Mem  [DMEM_DEPTH];
    logic signed [31:0] Reg_File  [32];

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      imm_q, imm_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      mdr_q, mdr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cycle_cnt_q, retire_cnt_q;

    logic        cyc_inc, ret_inc, rf_we, dm_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] ea;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    // Effective address for LW/SW and the ADDI sum share one adder.
    assign ea     = a_q + imm_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        err_d    = err_q;
        cyc_inc  = 1'b0;
        ret_inc  = 1'b0;
        rf_we    = 1'b0;
        dm_we    = 1'b0;
        rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
        rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;

        case (state_q)
            S_FETCH: begin
                if (run_i) begin
                    cyc_inc = 1'b1;
                    if (pc_q[1:0] != 2'b00 || pc_q[31:2] >= IMEM_WORDS) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        ir_d    = Instr_Mem[pc_q[IAW+1:2]];
                        pc_d    = pc_q + 32'd4;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                cyc_inc = 1'b1;
                a_d     = Reg_File[rs];
                b_d     = Reg_File[rt];
                imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
                state_d = S_EXEC;
            end
            S_EXEC: begin
                cyc_inc = 1'b1;
                state_d = S_WB;
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD:  alu_d = a_q + b_q;
                            FN_SUB:  alu_d = a_q - b_q;
                            FN_AND:  alu_d = a_q & b_q;
                            FN_OR:   alu_d = a_q | b_q;
                            FN_SLT:  alu_d = {31'b0, $signed(a_q) < $signed(b_q)};
                            default: begin
                                err_d   = 1'b1;
                                state_d = S_HALT;
                            end
                        endcase
                    end
                    OP_ADDI: alu_d = ea;
                    OP_SLTI: alu_d = {31'b0, $signed(a_q) < $signed(imm_q)};
                    OP_LW, OP_SW: begin
                        alu_d = ea;
                        if (ea[1:0] != 2'b00 || ea[31:2] >= DMEM_WORDS) begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            state_d = S_MEM;
                        end
                    end
                    OP_BEQ, OP_BNE: begin
                        // PC already points past the branch, so the offset is relative to PC+4.
                        if ((a_q == b_q) == (opcode == OP_BEQ))
                            pc_d = pc_q + {imm_q[29:0], 2'b00};
                        ret_inc = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        ret_inc = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        ret_inc = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                cyc_inc = 1'b1;
                if (opcode == OP_LW) begin
                    mdr_d   = Data_Mem[alu_q[DAW+1:2]];
                    state_d = S_WB;
                end else begin
                    dm_we   = 1'b1;
                    ret_inc = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                cyc_inc = 1'b1;
                rf_we   = (rf_waddr != 5'd0);
                ret_inc = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the values from before this edge regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            imm_q        <= '0;
            alu_q        <= '0;
            mdr_q        <= '0;
            err_q        <= 1'b0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            // NOTE: the register file and data memory are architecturally cleared by reset,
            // so they are built from flops; the instruction memory is left alone.
            for (int i = 0; i < 32; i++)         Reg_File[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) Data_Mem[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
            if (cyc_inc && cycle_cnt_q != '1)
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (ret_inc && retire_cnt_q != '1)
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            if (rf_we)
                Reg_File[rf_waddr] <= rf_wdata;
            if (dm_we)
                Data_Mem[alu_q[DAW+1:2]] <= b_q;
        end
    end

    assign halted_o     = (state_q == S_HALT);
    assign err_o        = err_q;
    assign pc_o         = pc_q;
    assign state_o      = state_q;
    assign cycle_cnt_o  = cycle_cnt_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_mips_multicycle_sim.sv
// Self-checking bench for mips_multicycle_sim: directed program table, corner-case sequences,
// and random programs compared against an instruction-level reference model.
module tb_mips_multicycle_sim;
    localparam int          IMEM_DEPTH = 256;
    localparam int          DMEM_DEPTH = 256;
    localparam logic [31:0] HALT_W     = 32'hFC00_0000;
    localparam logic [31:0] BAD_W      = 32'hF800_0000;

    localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        run_i = 1'b0;
    logic        halted_o, err_o;
    logic [31:0] pc_o;
    logic [2:0]  state_o;
    logic [31:0] cycle_cnt_o, retire_cnt_o;

    always #5 clk = ~clk;

    mips_multicycle_sim #(
        .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .RESET_PC(32'h0), .CNT_W(32)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .run_i(run_i),
        .halted_o(halted_o), .err_o(err_o), .pc_o(pc_o), .state_o(state_o),
        .cycle_cnt_o(cycle_cnt_o), .retire_cnt_o(retire_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: an instruction-at-a-time interpreter.
    logic [31:0] m_imem [IMEM_DEPTH];
    int          m_reg  [32];
    logic [31:0] m_dmem [DMEM_DEPTH];
    logic [31:0] m_pc;
    int          m_ret, m_cyc;
    bit          m_err;

    typedef struct {
        string             name;
        logic [0:7][31:0]  prog;
        int                ra; logic [31:0] ea;
        int                rb; logic [31:0] eb;
        int                rc; logic [31:0] ec;
        int                dm_idx; logic [31:0] dm_val;
        logic [31:0]       exp_pc, exp_ret, exp_cyc;
        logic              exp_err;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int word_target);
        return {OP_J, 26'(word_target)};
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        run_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < IMEM_DEPTH; i++) m_imem[i] = HALT_W;
    endtask

    task automatic load_imem();
        for (int i = 0; i < IMEM_DEPTH; i++) dut.Instr_Mem[i] = m_imem[i];
    endtask

    task automatic run_to_halt(input bit rand_run);
        int k;
        k = 0;
        run_i = 1'b1;
        while (!halted_o && k < 3000) begin
            @(posedge clk);
            #1;
            if (rand_run) run_i = ($urandom_range(0, 3) != 0);
            k++;
        end
        run_i = 1'b0;
    endtask

    task automatic model_run();
        logic [31:0] ir, addr;
        logic [5:0]  op, fn;
        int          rs, rt, rd, a, b, imm, val, dest, lat;
        bit          bad, wr, done;
        for (int i = 0; i < 32; i++)         m_reg[i]  = 0;
        for (int i = 0; i < DMEM_DEPTH; i++) m_dmem[i] = '0;
        m_pc = 32'h0; m_ret = 0; m_cyc = 0; m_err = 1'b0; done = 1'b0;
        for (int step = 0; step < 4000 && !done; step++) begin
            if (m_pc % 4 != 0 || m_pc / 4 >= IMEM_DEPTH) begin
                m_err = 1'b1; m_cyc += 1; done = 1'b1;
            end else begin
                ir = m_imem[m_pc / 4];
                m_pc = m_pc + 4;
                op = ir[31:26]; fn = ir[5:0];
                rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
                a = m_reg[rs]; b = m_reg[rt];
                imm = $signed(ir[15:0]);
                bad = 1'b0; wr = 1'b0; dest = rt; val = 0; lat = 4;
                addr = 32'(a + imm);
                case (op)
                    6'h00: begin
                        wr = 1'b1; dest = rd;
                        case (fn)
                            FN_ADD:  val = a + b;
                            FN_SUB:  val = a - b;
                            FN_AND:  val = a & b;
                            FN_OR:   val = a | b;
                            FN_SLT:  val = (a < b) ? 1 : 0;
                            default: bad = 1'b1;
                        endcase
                    end
                    OP_ADDI: begin wr = 1'b1; val = a + imm; end
                    OP_SLTI: begin wr = 1'b1; val = (a < imm) ? 1 : 0; end
                    OP_LW, OP_SW: begin
                        if (addr % 4 != 0 || addr / 4 >= DMEM_DEPTH) bad = 1'b1;
                        else if (op == OP_LW) begin wr = 1'b1; val = int'(m_dmem[addr / 4]); lat = 5; end
                        else m_dmem[addr / 4] = 32'(b);
                    end
                    OP_BEQ, OP_BNE: begin
                        lat = 3;
                        if ((a == b) == (op == OP_BEQ)) m_pc = m_pc + 32'(imm * 4);
                    end
                    OP_J: begin lat = 3; m_pc = {m_pc[31:28], ir[25:0], 2'b00}; end
                    OP_HALT: begin lat = 3; done = 1'b1; end
                    default: bad = 1'b1;
                endcase
                if (bad) begin
                    m_err = 1'b1; m_cyc += 3; done = 1'b1;
                end else begin
                    m_cyc += lat; m_ret++;
                    if (wr && dest != 0) m_reg[dest] = val;
                end
            end
        end
    endtask

    task automatic gen_prog(input int len);
        int k, rs, rt, rd;
        logic [5:0] fn;
        clear_prog();
        for (int i = 0; i < len; i++) begin
            k  = $urandom_range(0, 23);
            rs = $urandom_range(0, 7);
            rt = $urandom_range(0, 7);
            rd = $urandom_range(0, 7);
            case ($urandom_range(0, 4))
                0: fn = FN_ADD; 1: fn = FN_SUB; 2: fn = FN_AND; 3: fn = FN_OR; default: fn = FN_SLT;
            endcase
            if (k < 6)       m_imem[i] = enc_r(fn, rd, rs, rt);
            else if (k < 10) m_imem[i] = enc_i(OP_ADDI, rt, rs, int'($urandom_range(0, 65535)) - 32768);
            else if (k < 12) m_imem[i] = enc_i(OP_ADDI, rt, rs, int'($urandom_range(0, 6)) - 3);
            else if (k < 14) m_imem[i] = enc_i(OP_SLTI, rt, rs, int'($urandom_range(0, 40)) - 20);
            else if (k < 16) m_imem[i] = enc_i(OP_SW, rt, 0, 4 * int'($urandom_range(0, 15)));
            else if (k < 18) m_imem[i] = enc_i(OP_LW, rt, 0, 4 * int'($urandom_range(0, 15)));
            else if (k < 21) m_imem[i] = enc_i(($urandom_range(0, 1) != 0) ? OP_BEQ : OP_BNE, rt, rs,
                                               int'($urandom_range(0, 2)));
            else if (k < 23) m_imem[i] = enc_j(i + 1 + int'($urandom_range(0, 2)));
            else             m_imem[i] = enc_i(OP_LW, rt, 0, 4 * int'($urandom_range(0, 15)) + 2);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   k;

        vecs[0] = '{name:"arith",
            prog:{enc_i(OP_ADDI,1,0,5), enc_i(OP_ADDI,2,0,-3), enc_r(FN_ADD,3,1,2), enc_r(FN_SUB,4,2,1),
                  enc_r(FN_SLT,5,2,1), HALT_W, HALT_W, HALT_W},
            ra:3, ea:32'd2, rb:4, eb:32'hFFFF_FFF8, rc:5, ec:32'd1, dm_idx:0, dm_val:32'h0,
            exp_pc:32'd24, exp_ret:32'd6, exp_cyc:32'd23, exp_err:1'b0};
        vecs[1] = '{name:"mem",
            prog:{enc_i(OP_ADDI,1,0,8), enc_i(OP_ADDI,2,0,32'h77), enc_i(OP_SW,2,1,4), enc_i(OP_LW,3,0,12),
                  HALT_W, HALT_W, HALT_W, HALT_W},
            ra:1, ea:32'd8, rb:2, eb:32'h77, rc:3, ec:32'h77, dm_idx:3, dm_val:32'h77,
            exp_pc:32'd20, exp_ret:32'd5, exp_cyc:32'd20, exp_err:1'b0};
        vecs[2] = '{name:"loop",
            prog:{enc_i(OP_ADDI,1,0,3), enc_i(OP_ADDI,1,1,-1), enc_i(OP_BNE,0,1,-2), enc_i(OP_ADDI,2,0,7),
                  enc_j(6), enc_i(OP_ADDI,3,0,99), HALT_W, HALT_W},
            ra:1, ea:32'd0, rb:2, eb:32'd7, rc:3, ec:32'd0, dm_idx:0, dm_val:32'h0,
            exp_pc:32'd28, exp_ret:32'd10, exp_cyc:32'd35, exp_err:1'b0};
        vecs[3] = '{name:"bad_opcode",
            prog:{enc_i(OP_ADDI,0,0,9), BAD_W, enc_i(OP_ADDI,1,0,1), HALT_W, HALT_W, HALT_W, HALT_W, HALT_W},
            ra:0, ea:32'd0, rb:1, eb:32'd0, rc:2, ec:32'd0, dm_idx:0, dm_val:32'h0,
            exp_pc:32'd8, exp_ret:32'd1, exp_cyc:32'd7, exp_err:1'b1};
        vecs[4] = '{name:"lw_misaligned",
            prog:{enc_i(OP_LW,1,0,2), HALT_W, HALT_W, HALT_W, HALT_W, HALT_W, HALT_W, HALT_W},
            ra:1, ea:32'd0, rb:0, eb:32'd0, rc:2, ec:32'd0, dm_idx:0, dm_val:32'h0,
            exp_pc:32'd4, exp_ret:32'd0, exp_cyc:32'd3, exp_err:1'b1};
        vecs[5] = '{name:"lw_out_of_range",
            prog:{enc_i(OP_ADDI,1,0,5), enc_i(OP_LW,1,0,4*DMEM_DEPTH), HALT_W, HALT_W, HALT_W, HALT_W,
                  HALT_W, HALT_W},
            ra:1, ea:32'd5, rb:0, eb:32'd0, rc:2, ec:32'd0, dm_idx:0, dm_val:32'h0,
            exp_pc:32'd8, exp_ret:32'd1, exp_cyc:32'd7, exp_err:1'b1};
        vecs[6] = '{name:"logic_beq",
            prog:{enc_i(OP_ADDI,1,0,32'hF0), enc_i(OP_ADDI,2,0,32'hFF), enc_r(FN_AND,3,1,2), enc_r(FN_OR,4,1,2),
                  enc_i(OP_BEQ,1,3,1), enc_i(OP_ADDI,4,0,1), enc_i(OP_SLTI,5,2,-1), HALT_W},
            ra:3, ea:32'hF0, rb:4, eb:32'hFF, rc:5, ec:32'd0, dm_idx:0, dm_val:32'h0,
            exp_pc:32'd32, exp_ret:32'd7, exp_cyc:32'd26, exp_err:1'b0};
        vecs[7] = '{name:"pc_out_of_range",
            prog:{enc_j(IMEM_DEPTH), HALT_W, HALT_W, HALT_W, HALT_W, HALT_W, HALT_W, HALT_W},
            ra:0, ea:32'd0, rb:1, eb:32'd0, rc:2, ec:32'd0, dm_idx:0, dm_val:32'h0,
            exp_pc:32'd1024, exp_ret:32'd1, exp_cyc:32'd4, exp_err:1'b1};

        // Reset state, then a 10-cycle run_i=0 hold before running the arithmetic program.
        do_reset();
        check("reset pc", pc_o, 32'h0);
        check("reset state", 32'(state_o), 32'd0);
        check("reset halted", 32'(halted_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset cycle_cnt", cycle_cnt_o, 32'd0);
        check("reset retire_cnt", retire_cnt_o, 32'd0);
        clear_prog();
        for (int i = 0; i < 8; i++) m_imem[i] = vecs[0].prog[i];
        load_imem();
        repeat (10) @(posedge clk);
        #1;
        check("hold state", 32'(state_o), 32'd0);
        check("hold cycle_cnt", cycle_cnt_o, 32'd0);
        check("hold retire_cnt", retire_cnt_o, 32'd0);
        check("hold pc", pc_o, 32'h0);
        run_to_halt(1'b0);
        check("hold then run cycle_cnt", cycle_cnt_o, 32'd23);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            clear_prog();
            for (int i = 0; i < 8; i++) m_imem[i] = vecs[v].prog[i];
            load_imem();
            run_to_halt(1'b0);
            check($sformatf("%s r%0d", vecs[v].name, vecs[v].ra), dut.Reg_File[vecs[v].ra], vecs[v].ea);
            check($sformatf("%s r%0d", vecs[v].name, vecs[v].rb), dut.Reg_File[vecs[v].rb], vecs[v].eb);
            check($sformatf("%s r%0d", vecs[v].name, vecs[v].rc), dut.Reg_File[vecs[v].rc], vecs[v].ec);
            check($sformatf("%s dmem[%0d]", vecs[v].name, vecs[v].dm_idx), dut.Data_Mem[vecs[v].dm_idx],
                  vecs[v].dm_val);
            check($sformatf("%s pc", vecs[v].name), pc_o, vecs[v].exp_pc);
            check($sformatf("%s retire_cnt", vecs[v].name), retire_cnt_o, vecs[v].exp_ret);
            check($sformatf("%s cycle_cnt", vecs[v].name), cycle_cnt_o, vecs[v].exp_cyc);
            check($sformatf("%s err", vecs[v].name), 32'(err_o), 32'(vecs[v].exp_err));
            check($sformatf("%s halted", vecs[v].name), 32'(halted_o), 32'd1);
            check($sformatf("%s state", vecs[v].name), 32'(state_o), 32'd5);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("%s frozen pc", vecs[v].name), pc_o, vecs[v].exp_pc);
            check($sformatf("%s frozen cycle_cnt", vecs[v].name), cycle_cnt_o, vecs[v].exp_cyc);
        end

        // LW latency: count cycles between the SW retiring and the LW retiring.
        do_reset();
        clear_prog();
        m_imem[0] = enc_i(OP_ADDI, 1, 0, 32'h55);
        m_imem[1] = enc_i(OP_SW, 1, 0, 8);
        m_imem[2] = enc_i(OP_LW, 3, 0, 8);
        load_imem();
        run_i = 1'b1;
        k = 0;
        while (retire_cnt_o != 32'd2 && k < 50) begin @(posedge clk); #1; k++; end
        k = 0;
        while (retire_cnt_o != 32'd3 && k < 50) begin @(posedge clk); #1; k++; end
        check("lw latency cycles", 32'(k), 32'd5);
        run_to_halt(1'b0);
        check("lw loaded r3", dut.Reg_File[3], 32'h55);

        // Reset asserted during the EXEC of an ADD discards everything.
        do_reset();
        clear_prog();
        m_imem[0] = enc_i(OP_ADDI, 1, 0, 5);
        m_imem[1] = enc_r(FN_ADD, 2, 1, 1);
        load_imem();
        run_i = 1'b1;
        k = 0;
        while (!(state_o == 3'd2 && retire_cnt_o == 32'd1) && k < 50) begin @(posedge clk); #1; k++; end
        check("rst_exec reached EXEC", 32'(state_o), 32'd2);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst_exec pc", pc_o, 32'h0);
        check("rst_exec state", 32'(state_o), 32'd0);
        check("rst_exec cycle_cnt", cycle_cnt_o, 32'd0);
        check("rst_exec retire_cnt", retire_cnt_o, 32'd0);
        check("rst_exec r1", dut.Reg_File[1], 32'd0);
        check("rst_exec r2", dut.Reg_File[2], 32'd0);
        rst_i = 1'b0;
        run_to_halt(1'b0);
        check("rst_exec rerun r2", dut.Reg_File[2], 32'd10);
        check("rst_exec rerun retire_cnt", retire_cnt_o, 32'd3);

        // Random programs with a randomly toggling run gate against the reference model.
        for (int t = 0; t < 25; t++) begin
            gen_prog(12);
            model_run();
            do_reset();
            load_imem();
            run_to_halt(1'b1);
            for (int i = 0; i < 8; i++)
                check($sformatf("rand%0d r%0d", t, i), dut.Reg_File[i], 32'(m_reg[i]));
            for (int i = 0; i < 16; i++)
                check($sformatf("rand%0d dmem[%0d]", t, i), dut.Data_Mem[i], m_dmem[i]);
            check($sformatf("rand%0d pc", t), pc_o, m_pc);
            check($sformatf("rand%0d retire_cnt", t), retire_cnt_o, 32'(m_ret));
            check($sformatf("rand%0d cycle_cnt", t), cycle_cnt_o, 32'(m_cyc));
            check($sformatf("rand%0d err", t), 32'(err_o), 32'(m_err));
            check($sformatf("rand%0d halted", t), 32'(halted_o), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_sim.md
Name: mips_multicycle_sim

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS instruction simulator. It executes the MIPS subset from an internal instruction memory through an explicit FETCH/DECODE/EXEC/MEM/WB state machine. Compared with the single-cycle simulator it adds BNE, J, a HALT opcode, full base+offset addressing, error detection, a run gate, and cycle and retire counters. The bench loads Instr_Mem hierarchically after reset and inspects Reg_File and Data_Mem the same way.

Parameters:
IMEM_DEPTH, 256, words in Instr_Mem (power of 2)
DMEM_DEPTH, 256, words in Data_Mem (power of 2)
RESET_PC, 0, byte address loaded into PC on reset (word aligned)
CNT_W, 32, width of cycle and retire counters

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  reset; synchronous, active-high
run_i  in  1  run gate; sampled only in FETCH
halted_o  out  1  high once HALT is executed or an error occurs; sticky until reset
err_o  out  1  error flag; sticky until reset
pc_o  out  32  current PC (byte address)
state_o  out  3  FSM state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT
cycle_cnt_o  out  CNT_W  cycles spent outside FETCH-stall and HALT
retire_cnt_o  out  CNT_W  instructions completed

Behaviour:
- Internal arrays: Instr_Mem[IMEM_DEPTH] x32, Data_Mem[DMEM_DEPTH] x32, Reg_File[32] signed x32.
- Reset (rst_i=1 at a rising edge):
  - PC=RESET_PC; state=FETCH.
  - Reg_File and Data_Mem all zero; Instr_Mem untouched.
  - halted_o=0, err_o=0, both counters 0.
  - Reset mid-instruction discards all partial results.
- FETCH:
  - If run_i=0, hold with no counter change.
  - Else check PC[1:0]!=0 or PC>>2 >= IMEM_DEPTH; if either, set err and go to HALT.
  - Otherwise latch IR=Instr_Mem[PC>>2], set PC=PC+4, go to DECODE.
- DECODE: latch A=Reg_File[rs], B=Reg_File[rt], imm=sign-extended IR[15:0]; go to EXEC.
- EXEC, by opcode/funct:
  - R-type funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed): ALUout computed, go to WB.
  - ADDI 0x08 and SLTI 0x0A (signed): ALUout from A and imm, go to WB.
  - LW 0x23 / SW 0x2B: addr=A+imm.
    - If addr[1:0]!=0 or addr>>2 >= DMEM_DEPTH, set err and go to HALT.
    - Otherwise go to MEM.
  - BEQ 0x04 / BNE 0x05: if taken, PC=PC+(imm<<2) (PC already incremented); retire; go to FETCH.
  - J 0x02: PC={PC[31:28], IR[25:0], 2'b00}; retire; go to FETCH.
  - HALT 0x3F: retire; go to HALT.
  - Any other opcode or funct: set err, go to HALT.
- MEM:
  - LW latches MDR=Data_Mem[addr>>2], go to WB.
  - SW writes Data_Mem[addr>>2]=B, retires, go to FETCH.
- WB:
  - Destination is rd for R-type, rt for I-type; write ALUout or MDR there.
  - A write to register 0 is discarded, so Reg_File[0] always reads 0.
  - Retire, go to FETCH.
- Latency in cycles: branch/J/HALT 3; R-type/ADDI/SLTI/SW 4; LW 5.
- Arithmetic is 32-bit two's complement with wrap-around and no overflow trap. PC arithmetic wraps at 32 bits.
- HALT state: absorbing until reset; halted_o=1; counters frozen; no memory or register writes.
- Counters:
  - cycle_cnt increments on every cycle in DECODE/EXEC/MEM/WB, and in FETCH when run_i=1.
  - retire_cnt increments at the retire points listed above.
  - Both saturate at all-ones.
- Error instruction: produces no architectural write and does not increment retire_cnt.

Test Plan:
- ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SUB r4,r2,r1; SLT r5,r2,r1; HALT -> r3=2, r4=-8, r5=1, retire_cnt=6, cycle_cnt=23, halted_o=1, err_o=0.
- ADDI r1,r0,8; ADDI r2,r0,0x77; SW r2,4(r1); LW r3,12(r0); HALT -> Data_Mem[3]=0x77, r3=0x77; LW takes exactly 5 cycles.
- Countdown loop r1=3; loop: ADDI r1,r1,-1; BNE r1,r0,-2; then J to HALT -> r1=0, retire_cnt=10, ending PC=HALT address+4.
- ADDI r0,r0,9; undefined opcode 0x3E -> r0 reads 0; err_o=1 and halted_o=1 after EXEC; PC frozen; later instructions never executed.
- LW r1,2(r0) -> misaligned, err_o=1. Separately, LW with address 4*DMEM_DEPTH -> err_o=1, no load performed.
- Hold run_i=0 for 10 cycles, then 1 -> state_o=0 and counters unchanged while held. Assert rst_i during the EXEC of an ADD -> next cycle PC=RESET_PC, Reg_File zeroed, counters 0.
